// File: rtl/seg7_pkg.sv
// Shared constants for the hex 7-segment scanner: segment width, the
// bit position of each segment in {g,f,e,d,c,b,a}, and the active-high font.
package seg7_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [SEG_W-1:0] M_A = 7'(1 << SEG_A);
    localparam logic [SEG_W-1:0] M_B = 7'(1 << SEG_B);
    localparam logic [SEG_W-1:0] M_C = 7'(1 << SEG_C);
    localparam logic [SEG_W-1:0] M_D = 7'(1 << SEG_D);
    localparam logic [SEG_W-1:0] M_E = 7'(1 << SEG_E);
    localparam logic [SEG_W-1:0] M_F = 7'(1 << SEG_F);
    localparam logic [SEG_W-1:0] M_G = 7'(1 << SEG_G);

    // Lit segments per hex digit, 1 = lit.
    localparam logic [SEG_W-1:0] FONT [16] = '{
        M_A | M_B | M_C | M_D | M_E | M_F,         // 0
        M_B | M_C,                                 // 1
        M_A | M_B | M_D | M_E | M_G,               // 2
        M_A | M_B | M_C | M_D | M_G,               // 3
        M_B | M_C | M_F | M_G,                     // 4
        M_A | M_C | M_D | M_F | M_G,               // 5
        M_A | M_C | M_D | M_E | M_F | M_G,         // 6
        M_A | M_B | M_C,                           // 7
        M_A | M_B | M_C | M_D | M_E | M_F | M_G,   // 8
        M_A | M_B | M_C | M_D | M_F | M_G,         // 9
        M_A | M_B | M_C | M_E | M_F | M_G,         // A
        M_C | M_D | M_E | M_F | M_G,               // b
        M_A | M_D | M_E | M_F,                     // C
        M_B | M_C | M_D | M_E | M_G,               // d
        M_A | M_D | M_E | M_F | M_G,               // E
        M_A | M_E | M_F | M_G                      // F
    };

endpackage

// File: rtl/seg7_hex_font.sv
// Combinational hex-nibble to 7-segment decoder, active-high output.
// Ports: nib (4-bit value), seg ({g,f,e,d,c,b,a}, 1 = lit).
module seg7_hex_font
    import seg7_pkg::*;
(
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] seg
);

    assign seg = FONT[nib];

endmodule

// File: rtl/seg7_hex_scan.sv
// Time-multiplexed hex 7-segment driver with tear-free frame buffering.
// Ports: clk, rst_n (async low), load_valid/load_ready/load_data handshake,
// blank_mask (live per-digit blank), seg {g..a} and one-hot digit_en.
module seg7_hex_scan
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0,
    parameter bit LZ_BLANK       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [SEG_W-1:0]        seg,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Output levels meaning "nothing lit" at the pin polarity.
    localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seg7_hex_scan: NUM_DIGITS must be 1..8");
        end
        if (SCAN_DIV < 2) begin : g_bad_div
            $error("seg7_hex_scan: SCAN_DIV must be >= 2");
        end
    endgenerate

    logic [DW-1:0]         disp_q, disp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;

    logic                  wrap;
    logic                  frame_end;
    logic                  accept;
    logic [3:0]            nib;
    logic [SEG_W-1:0]      font_seg;
    logic [NUM_DIGITS-1:0] sel;
    logic [NUM_DIGITS-1:0] lz;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zrun;
    logic                  dark;
    logic                  lit;

    assign load_ready = !pend_full_q;
    assign seg        = seg_q;
    assign digit_en   = dig_q;

    // Scan counters and the pend -> disp hand-off at the frame boundary.
    always_comb begin
        wrap        = (div_q == DIV_LAST);
        frame_end   = wrap && (idx_q == IDX_LAST);
        accept      = load_valid && !pend_full_q;

        div_d       = wrap ? '0 : div_q + 1'b1;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;

        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Accept needs an empty buffer, transfer needs a full one, so
        // the two branches never fire together.
        if (accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end
        if (frame_end && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
    end

    // Current digit select and leading-zero run from the top digit down.
    always_comb begin
        sel  = '0;
        nib  = '0;
        lz   = '0;
        zrun = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zrun  = zrun & (disp_q[4*i +: 4] == 4'h0);
            lz[i] = zrun;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel[i] = 1'b1;
                nib    = disp_q[4*i +: 4];
            end
        end
    end

    seg7_hex_font u_font (
        .nib (nib),
        .seg (font_seg)
    );

    // div==0 is the anti-ghosting gap; polarity is applied last.
    always_comb begin
        lz_mask    = lz;
        lz_mask[0] = 1'b0;
        if (!LZ_BLANK) begin
            lz_mask = '0;
        end
        dark  = |(sel & (blank_mask | lz_mask));
        lit   = (div_q != '0) && !dark;
        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        if (lit) begin
            seg_d = font_seg ^ SEG_OFF;
            dig_d = sel ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            div_q       <= '0;
            idx_q       <= '0;
            seg_q       <= SEG_OFF;
            dig_q       <= DIG_OFF;
        end else begin
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
        end
    end

endmodule
